// File: rtl/alu_result_fifo.sv
// ============================================================================
// alu_result_fifo
// ----------------------------------------------------------------------------
// Purpose:
//   Registered result buffer that sits directly downstream of the 32-bit ALU.
//   Each valid ALU result and its zero flag are captured into a first-in
//   first-out queue. The consumer (writeback stage or a bench scoreboard)
//   takes results through a valid/ready handshake.
//
//   The ALU cannot be stalled. When the queue is full, an incoming result is
//   discarded and the sticky overflow flag is raised. The flag stays high
//   until clear.
//
// Parameters:
//   DEPTH  number of entries; must be a power of two and at least 2
//   WIDTH  data width; matches the ALU result width
//
// Ports:
//   clk_i           single clock; everything is sampled on the rising edge
//   clear_i         asynchronous, active-high reset
//   in_valid_i      the ALU result is valid this cycle
//   in_data_i       ALU result (alu_out)
//   in_zero_i       ALU zero flag belonging to in_data_i
//   in_ready_o      high while the queue is not full
//   out_valid_o     the head entry is available
//   out_data_o      head entry data (reads 0 while out_valid_o is low)
//   out_zero_o      head entry zero flag (reads 0 while out_valid_o is low)
//   out_ready_i     the consumer accepts the head entry
//   count_o         current occupancy, 0..DEPTH
//   overflow_o      sticky flag: a result was dropped while the queue was full
//   result_count_o  accepted pushes, saturating at 16'hFFFF
//                   (only with ALU_RESULT_STATS_EN)
//   zero_count_o    accepted pushes carrying in_zero_i = 1, saturating
//                   (only with ALU_RESULT_STATS_EN)
//
// Configuration macro:
//   ALU_RESULT_STATS_EN  when defined, adds the two statistics counters and
//                        their output ports. All other behaviour is the same.
// ============================================================================
module alu_result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   clear_i,
    input  logic                   in_valid_i,
    input  logic [WIDTH-1:0]       in_data_i,
    input  logic                   in_zero_i,
    output logic                   in_ready_o,
    output logic                   out_valid_o,
    output logic [WIDTH-1:0]       out_data_o,
    output logic                   out_zero_o,
    input  logic                   out_ready_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o
`ifdef ALU_RESULT_STATS_EN
    ,
    output logic [15:0]            result_count_o,
    output logic [15:0]            zero_count_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Each entry stores {zero, data}; the zero flag is kept exactly as
    // received from the ALU and is never recomputed here.
    logic [WIDTH:0]  mem_q [DEPTH];

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            overflow_q, overflow_d;

    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [WIDTH:0]  head;

    // Full and empty come only from the registered occupancy. As a result,
    // in_ready_o has no combinational path from out_ready_i: a pop at full
    // frees a slot that can only be used from the following cycle.
    always_comb begin
        full        = (count_q == FULL_COUNT);
        empty       = (count_q == '0);
        in_ready_o  = !full;
        out_valid_o = !empty;
        push        = in_valid_i && !full;
        pop         = !empty && out_ready_i;
    end

    // Head entry presentation. The outputs are masked while the queue is
    // empty, so out_data_o and out_zero_o read 0 during and after clear,
    // even though the storage array itself is not reset.
    always_comb begin
        head       = mem_q[rd_ptr_q];
        out_data_o = '0;
        out_zero_o = 1'b0;
        if (!empty) begin
            out_data_o = head[WIDTH-1:0];
            out_zero_o = head[WIDTH];
        end
    end

    // Next-state logic for the pointers, the occupancy and the sticky flag.
    // Pointers are AW bits wide and wrap modulo DEPTH through natural
    // overflow, which relies on DEPTH being a power of two.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A result offered while the queue is full is lost; remember that.
        if (in_valid_i && full) begin
            overflow_d = 1'b1;
        end
    end

    // Control state register. clear_i takes effect immediately, so any
    // partially complete push or pop is abandoned.
    always_ff @(posedge clk_i or posedge clear_i) begin
        if (clear_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array. It is left unreset because its contents are only ever
    // observed through the masked head outputs.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_zero_i, in_data_i};
        end
    end

    assign count_o    = count_q;
    assign overflow_o = overflow_q;

`ifdef ALU_RESULT_STATS_EN
    logic [15:0] result_count_q, result_count_d;
    logic [15:0] zero_count_q,   zero_count_d;

    // Statistics count accepted pushes only; dropped results are not counted.
    // Both counters saturate at 16'hFFFF.
    always_comb begin
        result_count_d = result_count_q;
        zero_count_d   = zero_count_q;
        if (push) begin
            if (result_count_q != 16'hFFFF) begin
                result_count_d = result_count_q + 16'd1;
            end
            if (in_zero_i && (zero_count_q != 16'hFFFF)) begin
                zero_count_d = zero_count_q + 16'd1;
            end
        end
    end

    // Statistics registers; only clear_i resets them.
    always_ff @(posedge clk_i or posedge clear_i) begin
        if (clear_i) begin
            result_count_q <= '0;
            zero_count_q   <= '0;
        end else begin
            result_count_q <= result_count_d;
            zero_count_q   <= zero_count_d;
        end
    end

    assign result_count_o = result_count_q;
    assign zero_count_o   = zero_count_q;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// ============================================================================
// tb_alu_result_fifo
// ----------------------------------------------------------------------------
// Directed testbench for alu_result_fifo (DEPTH=8, WIDTH=32).
//
// The driver applies vectors just after each rising edge and tracks the
// expected occupancy and overflow in a small model. Every result it expects
// to be accepted is pushed into a scoreboard queue. A separate monitor pops
// that queue on each falling edge where the DUT performs a handshake, and
// compares the head entry against the popped value.
// ============================================================================
module tb_alu_result_fifo;

    localparam int DEPTH = 8;
    localparam int WIDTH = 32;

    logic             clk;
    logic             clear;
    logic             inValid;
    logic [WIDTH-1:0] inData;
    logic             inZero;
    logic             inReady;
    logic             outValid;
    logic [WIDTH-1:0] outData;
    logic             outZero;
    logic             outReady;
    logic [3:0]       count;
    logic             overflow;
`ifdef ALU_RESULT_STATS_EN
    logic [15:0]      resultCount;
    logic [15:0]      zeroCount;
    int               modelResults;
    int               modelZeros;
`endif

    int               asserts;
    int               failures;
    int               modelCount;
    logic             modelOverflow;
    logic [WIDTH:0]   scoreboard[$];

    alu_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk_i       (clk),
        .clear_i     (clear),
        .in_valid_i  (inValid),
        .in_data_i   (inData),
        .in_zero_i   (inZero),
        .in_ready_o  (inReady),
        .out_valid_o (outValid),
        .out_data_o  (outData),
        .out_zero_o  (outZero),
        .out_ready_i (outReady),
        .count_o     (count),
        .overflow_o  (overflow)
`ifdef ALU_RESULT_STATS_EN
        ,
        .result_count_o (resultCount),
        .zero_count_o   (zeroCount)
`endif
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "[TB] timeout");
    end

    // Single comparison point shared by the driver and the monitor.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        asserts++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Compare the control outputs against the model.
    task automatic checkState(input string tag);
        checkOutput({tag, ".count"},    64'(count),    64'(modelCount));
        checkOutput({tag, ".inReady"},  64'(inReady),  64'(modelCount < DEPTH));
        checkOutput({tag, ".outValid"}, 64'(outValid), 64'(modelCount != 0));
        checkOutput({tag, ".overflow"}, 64'(overflow), 64'(modelOverflow));
`ifdef ALU_RESULT_STATS_EN
        checkOutput({tag, ".resultCount"}, 64'(resultCount), 64'(modelResults));
        checkOutput({tag, ".zeroCount"},   64'(zeroCount),   64'(modelZeros));
`endif
    endtask

    // Drive one cycle of inputs, update the model and scoreboard, and return
    // 1 time unit after the next rising edge.
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                                 input logic z, input logic r);
        logic doPush;
        logic doPop;
        inValid  = v;
        inData   = d;
        inZero   = z;
        outReady = r;
        doPush = v && (modelCount < DEPTH);
        doPop  = r && (modelCount > 0);
        if (doPush) begin
            scoreboard.push_back({z, d});
`ifdef ALU_RESULT_STATS_EN
            if (modelResults < 16'hFFFF) modelResults++;
            if (z && modelZeros < 16'hFFFF) modelZeros++;
`endif
        end
        if (v && !doPush) modelOverflow = 1'b1;
        @(posedge clk);
        #1;
        modelCount = modelCount + int'(doPush) - int'(doPop);
        inValid  = 1'b0;
        outReady = 1'b0;
    endtask

    // Reset the model along with the DUT.
    task automatic modelReset();
        scoreboard.delete();
        modelCount    = 0;
        modelOverflow = 1'b0;
`ifdef ALU_RESULT_STATS_EN
        modelResults = 0;
        modelZeros   = 0;
`endif
    endtask

    // Monitor: on every handshake, the head must equal the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            if (!clear && outValid && outReady) begin
                if (scoreboard.size() == 0) begin
                    asserts++;
                    failures++;
                    $display("[TB] FAIL monitorUnexpected: got %0h, expected no entry",
                             {outZero, outData});
                end else begin
                    checkOutput("monitorHead", 64'({outZero, outData}),
                                64'(scoreboard.pop_front()));
                end
            end
        end
    end

    initial begin
        asserts  = 0;
        failures = 0;
        inValid  = 1'b0;
        inData   = '0;
        inZero   = 1'b0;
        outReady = 1'b0;
        clear    = 1'b1;
        modelReset();

        // Reset values while clear is held.
        #3;
        checkState("reset");
        checkOutput("reset.outData", 64'(outData), 64'h0);
        checkOutput("reset.outZero", 64'(outZero), 64'h0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(posedge clk);
        #1;

        // Single result: visible one edge after the push, then popped.
        applyStimulus(1'b1, 32'h0000_0005, 1'b0, 1'b0);
        checkState("single.push");
        checkOutput("single.outData", 64'(outData), 64'h5);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkState("single.pop");

        // Fill to DEPTH with out_ready low; the head must stay stable.
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
            checkOutput("fill.headStable", 64'(outData), 64'h1);
        end
        checkState("fill.full");
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        checkState("fill.drop");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        end
        checkState("fill.drained");
        checkOutput("fill.scoreboardEmpty", 64'(scoreboard.size()), 64'h0);

        // Simultaneous push and pop at occupancy 3, spanning a pointer wrap.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b1);
            checkOutput("simul.count", 64'(count), 64'h3);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        end
        checkState("simul.drained");
        checkOutput("simul.scoreboardEmpty", 64'(scoreboard.size()), 64'h0);

        // Zero-flag carriage, starting from a clean reset so stats are known.
        clear = 1'b1;
        modelReset();
        #2;
        clear = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 32'h0000_0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        checkOutput("zero.first", 64'(outZero), 64'h1);
`ifdef ALU_RESULT_STATS_EN
        checkOutput("zero.resultCount", 64'(resultCount), 64'h2);
        checkOutput("zero.zeroCount",   64'(zeroCount),   64'h1);
`endif
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("zero.second", 64'(outZero), 64'h0);
        checkOutput("zero.secondData", 64'(outData), 64'hFFFF_FFFF);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkState("zero.drained");

        // Mid-operation asynchronous reset at count 5 with overflow set.
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        end
        checkState("midReset.before");
        #1;
        clear = 1'b1;
        modelReset();
        #1;
        checkState("midReset.during");
        #1;
        clear = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 32'h0000_0077, 1'b0, 1'b0);
        checkState("midReset.after");
        checkOutput("midReset.head", 64'(outData), 64'h77);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkState("midReset.drained");
        checkOutput("midReset.scoreboardEmpty", 64'(scoreboard.size()), 64'h0);

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
